// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: 4-entry byte FIFO fed by CPU stores, 8N1 serializer,
// and a status word with a sticky overflow flag.
module uart_tx_mmio #(
  parameter int unsigned BAUD_DIV     = 434,
  parameter logic [31:0] TX_DATA_ADDR = 32'h1001_0024,
  parameter logic [31:0] STATUS_ADDR  = 32'h1001_0028
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] data_address,
  input  logic [31:0] writedata,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        uart_tx
);

  // state | meaning
  // IDLE  | line high, waiting for a queued byte
  // START | start bit (0) on the line
  // DATA  | data bits LSB-first, bit_idx_q selects the bit being held
  // STOP  | stop bit (1); may chain straight into the next START
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t      state_q;
  logic [7:0]  fifo_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic        overflow_q;
  logic [15:0] baud_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        tx_q;

  logic push_req, push_ok, pop, full, empty, busy, status_clr, baud_done;

  wire unused_wdata = ^writedata[31:8];

  always_comb begin
    full       = (count_q == 3'd4);
    empty      = (count_q == 3'd0);
    busy       = (state_q != IDLE);
    baud_done  = (baud_cnt_q == BAUD_LAST);
    push_req   = memwrite && (data_address == TX_DATA_ADDR);
    push_ok    = push_req && !full;
    status_clr = memwrite && (data_address == STATUS_ADDR) && writedata[3];
    pop        = !empty && ((state_q == IDLE) || ((state_q == STOP) && baud_done));
  end

  always_comb begin
    read_data = 32'h0;
    if (memread && (data_address == STATUS_ADDR))
      read_data = {25'b0, count_q, overflow_q, empty, full, busy};
    hit = (data_address == TX_DATA_ADDR) || (data_address == STATUS_ADDR);
  end

  // A push into a full FIFO is dropped even if a pop frees a slot on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= 8'h00;
    end else begin
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= writedata[7:0];
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      if (push_req && full) overflow_q <= 1'b1;
      else if (status_clr)  overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      baud_cnt_q <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q    <= fifo_q[rd_ptr_q];
            state_q    <= START;
            tx_q       <= 1'b0;
            baud_cnt_q <= 16'd0;
          end
        end
        START: begin
          if (baud_done) begin
            state_q    <= DATA;
            bit_idx_q  <= 3'd0;
            baud_cnt_q <= 16'd0;
            tx_q       <= shift_q[0];
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt_q <= 16'd0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt_q <= 16'd0;
            if (pop) begin
              shift_q <= fifo_q[rd_ptr_q];
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx = tx_q;

endmodule
